// File: rtl/pcpi_mul_sequencer.sv
// rtl/pcpi_mul_sequencer.sv - 8x8 unsigned multiply sequenced over an external 4x4 multiplier in four steps
module pcpi_mul_sequencer #(
    parameter bit HOLD_RESULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic        abort,
    output logic [3:0]  mul_m,
    output logic [3:0]  mul_q,
    input  logic [7:0]  mul_p,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [15:0] result_q;
    logic        res_valid_q;
    logic [15:0] partial;

    // step[0] selects the high nibble of a, step[1] the high nibble of b
    always_comb begin
        mul_m = 4'h0;
        mul_q = 4'h0;
        if (state == STEP) begin
            mul_m = step[0] ? a_q[7:4] : a_q[3:0];
            mul_q = step[1] ? b_q[7:4] : b_q[3:0];
        end
    end

    always_comb begin
        partial = {8'h00, mul_p};
        case (step)
            2'd0:    partial = {8'h00, mul_p};
            2'd1,
            2'd2:    partial = {4'h0, mul_p, 4'h0};
            default: partial = {mul_p, 8'h00};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= 2'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc         <= 16'h0000;
            result_q    <= 16'h0000;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        acc   <= 16'h0000;
                        step  <= 2'd0;
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (abort) begin
                        state <= IDLE;
                        step  <= 2'd0;
                        acc   <= 16'h0000;
                    end else begin
                        acc  <= acc + partial;
                        step <= step + 2'd1;
                        if (step == 2'd3) begin
                            state       <= DONE;
                            res_valid_q <= 1'b1;
                            result_q    <= acc + partial;
                        end
                    end
                end
                DONE: begin
                    // abort wins over a simultaneous result handshake
                    if (abort) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        acc         <= 16'h0000;
                    end else if (res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign res_valid   = res_valid_q;
    assign result      = (HOLD_RESULT || res_valid_q) ? result_q : 16'h0000;

endmodule

// File: doc/pcpi_mul_sequencer.md
PCPI_MUL_SEQUENCER -- requirements
Module: pcpi_mul_sequencer

Interface
REQ-001 The block SHALL have one parameter: HOLD_RESULT, default 1. When 1, result keeps its last value after the result handshake; when 0, result reads 0 whenever res_valid is low.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_valid  input  1  requester presents an operand pair.
REQ-005 start_ready  output  1  sequencer can accept operands.
REQ-006 op_a  input  8  multiplicand, unsigned.
REQ-007 op_b  input  8  multiplier, unsigned.
REQ-008 abort  input  1  cancels any in-flight operation.
REQ-009 mul_m  output  4  nibble driven to the external combinational 4x4 multiplier (m operand).
REQ-010 mul_q  output  4  nibble driven to the external 4x4 multiplier (q operand).
REQ-011 mul_p  input  8  product returned combinationally by the 4x4 multiplier in the same cycle.
REQ-012 res_valid  output  1  result is available.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 result  output  16  unsigned product op_a*op_b.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, STEP (2-bit step counter 0..3) and DONE.
REQ-017 start_ready SHALL be high only in IDLE. A start handshake is start_valid&&start_ready at a rising edge.
REQ-018 On a start handshake, the block SHALL latch op_a/op_b, clear the 16-bit accumulator, set step=0 and enter STEP.
REQ-019 In STEP, mul_m/mul_q SHALL be driven as follows:
- step0: a[3:0]/b[3:0]
- step1: a[7:4]/b[3:0]
- step2: a[3:0]/b[7:4]
- step3: a[7:4]/b[7:4]
REQ-020 At each STEP edge, the accumulator SHALL add mul_p shifted left by 0, 4, 4 and 8 bits for steps 0 to 3 respectively. The sum is modulo 2^16; it cannot overflow for valid partials.
REQ-021 After the step3 edge the FSM SHALL enter DONE with res_valid=1 and result equal to the accumulator. With the start handshake at edge N, res_valid SHALL be high after edge N+4.
REQ-022 In IDLE and DONE, mul_m and mul_q SHALL be 0.
REQ-023 In DONE, result and res_valid SHALL be held stable until res_ready is high at an edge. The FSM SHALL then enter IDLE and res_valid SHALL fall.
REQ-024 There is no new-operation overlap: start_ready stays low in DONE even if res_ready is high. The minimum issue interval is 6 cycles with res_ready tied high.
REQ-025 abort in STEP or DONE SHALL force IDLE at the next edge, with res_valid=0 and the accumulator cleared. abort in IDLE SHALL be ignored, and a simultaneous start_valid is still accepted.
REQ-026 abort and res_ready high together in DONE: abort SHALL take priority. The next state is IDLE and the result is treated as discarded.
REQ-027 Changes on op_a/op_b after the start handshake SHALL NOT affect the in-flight result.
REQ-028 With HOLD_RESULT=1, result SHALL retain the last completed product through IDLE. An abort SHALL leave result at the previous completed value.
REQ-029 All outputs SHALL be derived from registers or from the FSM state only. There is no combinational path from any input to any output except through the registered state.

Reset
REQ-030 Assertion of rst_n low SHALL asynchronously force IDLE with step=0, accumulator=0, latched operands=0, result=0, res_valid=0, busy=0, start_ready=1, mul_m=0 and mul_q=0.
REQ-031 Reset asserted mid-operation SHALL discard the operation. No res_valid SHALL follow the release of reset.
REQ-032 After deassertion, the first start handshake SHALL be accepted on the first rising edge with start_valid high.

Verification
REQ-033 The bench SHALL cover at least the following directed scenarios, with a golden 4x4 multiplier model on mul_m/mul_q/mul_p:
- op_a=0x12, op_b=0x34, res_ready=1 -> res_valid 4 edges after the start handshake, result=0x03A8, then IDLE.
- op_a=0xFF, op_b=0xFF -> result=0xFE01; mul_m/mul_q sequence is F/F four times.
- op_a=0x00, op_b=0xA5 -> result=0x0000; res_ready held low 10 cycles -> res_valid and result stable, start_ready=0 throughout.
- abort pulsed during step2 of 0x80*0x80 -> IDLE next edge, res_valid never rises, result keeps the prior value; an immediate new start 0x02*0x03 -> 0x0006.
- rst_n pulsed low asynchronously (between edges) during step1 -> all outputs at reset values immediately; no res_valid after release.
- abort and res_ready both high in DONE -> IDLE, res_valid=0, start_ready=1 next cycle.
